program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Sits upstream of the 16x8 program RAM.
- Accepts a byte stream over a valid/ready handshake and writes it into consecutive RAM addresses starting at 0.
- Optionally verifies an 8-bit checksum, then releases the CPU core (PC, controller, IR) from hold.
- Replaces hard-coded RAM initialisation: programs are loaded at runtime from a host or boot source.

Parameters:
- DW, 8, data/instruction width in bits.
- AW, 4, RAM address width.
- DEPTH, 16, number of program bytes per load; 2 <= DEPTH <= 2**AW.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load.
- in_valid  in  1  source has a byte on in_data.
- in_data  in  DW  program byte (checksum byte in CHECK state).
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  RAM write strobe, registered.
- wr_addr  out  AW  RAM write address, registered.
- wr_data  out  DW  RAM write data, registered.
- cpu_hold  out  1  holds the CPU in reset while high.
- done  out  1  load completed successfully; level signal.
- err  out  1  checksum mismatch; level signal.

Behaviour:
- Reset (asynchronous) values:
  - state=IDLE, count=0, sum=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cpu_hold=1, done=0, err=0.
- Handshake:
  - A beat is accepted on any rising edge where in_valid && in_ready.
  - in_ready is combinational from state only: 1 in LOAD and CHECK, 0 otherwise.
  - in_data may change freely while in_valid=0.
- State IDLE:
  - start=1 -> LOAD; count<=0, sum<=0, cpu_hold stays 1.
  - All other inputs are ignored.
- State LOAD:
  - On each accepted beat, the next cycle drives wr_en=1, wr_addr=count, wr_data=in_data. Write latency is exactly 1 cycle.
  - On each accepted beat: count<=count+1 and sum<=sum+in_data (mod 2**DW, carry discarded).
  - wr_en=1 for exactly one cycle per accepted beat. Back-to-back beats produce back-to-back writes.
  - The beat accepted at count==DEPTH-1 -> CHECK (checksum enabled) or DONE (checksum disabled).
  - count never wraps past DEPTH-1.
- State CHECK:
  - On one accepted beat, no RAM write occurs.
  - in_data == sum -> DONE; otherwise -> ERR.
- State DONE:
  - cpu_hold=0, done=1, err=0.
  - start=1 -> LOAD; cpu_hold rises to 1 and done falls to 0 on the same edge, and count and sum clear.
- State ERR:
  - cpu_hold=1, err=1, done=0.
  - Only start (-> LOAD, err cleared) or reset exits.
- Outputs done, err and cpu_hold are registered and derived from the next state, so each changes on the same edge as the state transition.
- start while in LOAD or CHECK is ignored; the load is not restarted.
- in_valid held high in IDLE/DONE/ERR: no beat is accepted and no write occurs.
- Reset mid-load: all outputs return to reset values immediately (asynchronously). A partial RAM image is left as-is; cpu_hold=1 guarantees the CPU does not run it.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined: CHECK state exists as above; err can assert.
- Undefined: CHECK and ERR are not built. LOAD goes directly to DONE on the last beat, err is tied 0, and the sum register is not built.

Decomposition:
- Shared package cpuf_pkg holds:
  - DW/AW defaults.
  - Opcode constants (OP_LDA 4'b1000, OP_LDB 4'b0100, OP_ADD 4'b0010, OP_SUB 4'b0001, OP_JMP 4'b1001, OP_HLT 4'b1111).
  - Loader state enum loader_state_t {IDLE, LOAD, CHECK, DONE, ERR}.
- No sub-module: the single FSM with counter and accumulator is small enough to stay flat.

Test Plan:
- Reset, then no start for 10 cycles -> cpu_hold=1, in_ready=0, wr_en never 1, done=0, err=0.
- start; 16 back-to-back beats 0x00..0x0F; checksum 0x78 -> writes at addr 0..15 with data==addr, each 1 cycle after its beat; then done=1, cpu_hold=0, err=0.
- Same stream with checksum 0x77 -> no 17th write, err=1, cpu_hold=1, done=0; then a new start -> err=0, in_ready=1.
- in_valid toggled every other cycle with bytes 0x84,0x45,0x21,... -> one write per accepted beat, addresses contiguous, no duplicated or skipped address.
- Reset asserted after beat 7 of a load -> all outputs to reset values within the same cycle. Following start plus full stream -> writes begin at addr 0.
- Checksum macro undefined: 16 beats -> done=1 on the edge accepting beat 16, in_ready=0 afterwards, err constant 0.

Source files
------------

// File: rtl/cpuf_pkg.sv
// Shared definitions for the small CPU fabric: datapath widths, opcodes and
// the program loader state encoding.
package cpuf_pkg;

    localparam int CPUF_DW = 8;
    localparam int CPUF_AW = 4;

    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_LDB = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Program loader: streams DEPTH bytes over valid/ready into program RAM
// starting at address 0, then releases the CPU from hold.
// Optional trailing checksum verification: PROGRAM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start, CPU held
// LOAD  | accepting program bytes, one RAM write per beat
// CHECK | waiting for the checksum byte (checksum build only)
// DONE  | image loaded, CPU released
// ERR   | checksum mismatch, CPU held until next start (checksum build only)
module program_loader
    import cpuf_pkg::*;
#(
    parameter int DW    = CPUF_DW,
    parameter int AW    = CPUF_AW,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    loader_state_t state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          done_q, done_d;
    logic          beat;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;
    logic          err_q, err_d;
`endif

    // Ready depends on state only so the source never sees a combinational loop.
    assign in_ready = (state_q == LOAD) || (state_q == CHECK);
    assign beat     = in_valid && in_ready;

    // Next-state, write strobe and status outputs; status is taken from the next state.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                if (beat) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q;
                    wr_data_d = in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + in_data;
`endif
                    if (count_q == LAST) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (beat) begin
                    state_d = (in_data == sum_q) ? DONE : ERR;
                end
            end
            ERR: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                    sum_d   = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        cpu_hold_d = (state_d != DONE);
        done_d     = (state_d == DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        err_d      = (state_d == ERR);
`endif
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running checksum and error flag exist only when verification is built.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader against a cycle-level behavioural model.
module tb_program_loader;

    localparam int DEPTH = 16;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, wr_en, cpu_hold, done, err;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int n_vec = 0;
    int n_bad = 0;

    // model: phase 0 idle, 1 loading, 2 awaiting checksum, 3 done, 4 error
    int m_phase;
    int m_cnt;
    int m_sum;
    bit m_wr;
    int m_addr;
    int m_data;

    program_loader #(.DW(8), .AW(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return (m_phase == 1) || (m_phase == 2);
    endfunction

    task automatic m_reset();
        m_phase = 0; m_cnt = 0; m_sum = 0; m_wr = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic chk_status();
        chk("wr_en", wr_en, m_wr);
        if (m_wr) begin
            chk("wr_addr", wr_addr, m_addr);
            chk("wr_data", wr_data, m_data);
        end
        chk("done", done, m_phase == 3);
        chk("err", err, m_phase == 4);
        chk("cpu_hold", cpu_hold, m_phase != 3);
    endtask

    // One clock: drive at negedge, check ready, advance model at the edge, check outputs.
    task automatic cycle(input bit s, input bit v, input logic [7:0] d);
        bit acc;
        start = s; in_valid = v; in_data = d;
        #1;
        chk("in_ready", in_ready, m_ready());
        acc = v && m_ready();
        @(posedge clk);
        m_wr = 0;
        case (m_phase)
            0, 3, 4: if (s) begin m_phase = 1; m_cnt = 0; m_sum = 0; end
            1: if (acc) begin
                m_wr = 1; m_addr = m_cnt; m_data = d;
                m_sum = (m_sum + d) % 256;
                m_cnt++;
                if (m_cnt == DEPTH) m_phase = CK ? 2 : 3;
            end
            2: if (acc) m_phase = (d == m_sum) ? 3 : 4;
            default: ;
        endcase
        @(negedge clk);
        chk_status();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full load: start pulse, DEPTH beats with random gaps, optional checksum beat.
    task automatic run_load(input logic [7:0] img [DEPTH], input int gap_pct,
                            input bit noise, input bit bad_sum);
        int sum = 0;
        cycle(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(99) < gap_pct)
                cycle(noise && ($urandom_range(3) == 0), 1'b0, 8'($urandom));
            cycle(noise && ($urandom_range(3) == 0), 1'b1, img[i]);
            sum = (sum + img[i]) % 256;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        while ($urandom_range(99) < gap_pct)
            cycle(1'b0, 1'b0, 8'($urandom));
        cycle(noise && ($urandom_range(1) == 0), 1'b1, bad_sum ? 8'(sum + 1 + $urandom_range(254)) : 8'(sum));
`else
        if (bad_sum) sum = 0;
`endif
        cycle(1'b0, 1'b1, 8'($urandom));
        cycle(1'b0, 1'b1, 8'($urandom));
    endtask

    logic [7:0] img [DEPTH];

    initial begin
        m_reset();
        @(negedge clk);
        do_reset();

        // idle with no start, including in_valid held high
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'($urandom), 8'($urandom));

        // ramp image with correct checksum 0x78
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        run_load(img, 0, 1'b0, 1'b0);
        // same image, checksum 0x77
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, img[i]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        cycle(1'b0, 1'b1, 8'h77);
`endif
        cycle(1'b0, 1'b1, 8'h55);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        // toggled valid with a fixed-prefix stream
        do_reset();
        img[0] = 8'h84; img[1] = 8'h45; img[2] = 8'h21;
        for (int i = 3; i < DEPTH; i++) img[i] = 8'($urandom);
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b0, 8'($urandom));
            cycle(1'b0, 1'b1, img[i]);
        end
        cycle(1'b0, 1'b1, 8'(img[0]+img[1]+img[2]+img[3]+img[4]+img[5]+img[6]+img[7]+
                             img[8]+img[9]+img[10]+img[11]+img[12]+img[13]+img[14]+img[15]));
        cycle(1'b0, 1'b0, 8'h00);

        // reset after beat 7, then a full load must restart at address 0
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom));
        do_reset();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        run_load(img, 20, 1'b0, 1'b0);

        // randomized loads: gaps, ignored start pulses, good and bad checksums
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
            run_load(img, $urandom_range(60), 1'b1, 1'($urandom));
            for (int k = 0; k < 3; k++) cycle(1'b0, 1'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
